// File: rtl/wb_apb_pkg.sv
// Shared types and helpers for the APB/Wishbone bridges.
// Holds the bridge FSM encoding, default bus widths and the byte-select mask helper.
package wb_apb_pkg;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWbWait,
    StResp
  } bridge_state_e;

  // Mask with the low nbytes bits set; wide enough for data buses up to 512 bits.
  function automatic logic [63:0] sel_all_ones(input int unsigned nbytes);
    logic [63:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < nbytes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Cycle-count watchdog for Wishbone initiators waiting on ack/err.
// expired is high in the cycle the count reaches TIMEOUT_CYCLES-1; TIMEOUT_CYCLES=0 disables it.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_enabled
    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = enable && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/apb_to_wb.sv
// APB3 completer to Wishbone classic initiator bridge: one APB transfer becomes one
// Wishbone single cycle, with a watchdog turning a silent slave into PSLVERR.
module apb_to_wb
  import wb_apb_pkg::*;
#(
  parameter int unsigned AW             = DefAw,
  parameter int unsigned DW             = DefDw,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_o,
  output logic [DW/8-1:0] wb_sel,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack,
  input  logic          wb_err
);

  localparam int unsigned SW = DW / 8;
  localparam logic [SW-1:0] SelOnes = SW'(sel_all_ones(SW));

  bridge_state_e state_q;
  logic          abort_q;
  logic          wd_clear;
  logic          wd_enable;
  logic          wd_expired;
  logic          wb_done;
  logic          ack_ok;

  assign wd_clear  = (state_q == StIdle);
  assign wd_enable = (state_q == StWbWait);
  assign wb_done   = wb_ack || wb_err || wd_expired;
  // Clean completion only when ack arrives without err; err wins when both are high.
  assign ack_ok    = wb_ack && !wb_err;

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      abort_q  <= 1'b0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
      wb_sel   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (psel && !penable) begin
            wb_we    <= pwrite;
            wb_adr   <= paddr;
            wb_dat_o <= pwdata;
            wb_sel   <= pwrite ? pstrb : SelOnes;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            abort_q  <= 1'b0;
            state_q  <= StWbWait;
          end
        end
        StWbWait: begin
          if (!psel) abort_q <= 1'b1;
          if (wb_done) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            // A requester that dropped psel mid-transfer gets no response at all.
            if (abort_q || !psel) begin
              state_q <= StIdle;
            end else begin
              state_q <= StResp;
              pready  <= 1'b1;
              pslverr <= !ack_ok;
              prdata  <= (ack_ok && !wb_we) ? wb_dat_i : '0;
            end
          end
        end
        StResp: begin
          if (psel && penable) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
